// File: rtl/retospect_neuro_pkg.sv
// Shared constants for the CNB configuration chain and the LIF compute core.
// The weight slice offsets are common to the chain and the core.
package retospect_neuro_pkg;

  localparam int N_SYN      = 4;
  localparam int W_W        = 3;
  localparam int UT_W       = 4;
  localparam int DSEL_W     = 3;
  localparam int CFG_W_BITS = N_SYN * W_W;
  localparam int CFG_BITS   = 19;

  localparam int W1_LSB = 0;
  localparam int W2_LSB = 3;
  localparam int W3_LSB = 6;
  localparam int W4_LSB = 9;

  // Parallel view of the chain contents, MSB first as shifted in.
  typedef struct packed {
    logic [DSEL_W-1:0]     dsel;
    logic [UT_W-1:0]       ut;
    logic [CFG_W_BITS-1:0] w;
  } cfg_t;

  function automatic logic signed [W_W-1:0] weight_at(input logic [CFG_W_BITS-1:0] w,
                                                      input int idx);
    return w[idx*W_W +: W_W];
  endfunction

endpackage

// File: rtl/retospect_leak_prescaler.sv
// Leak prescaler: counts cycles and emits a tick every 2^sel cycles (sel=0 holds it at 0).
// A larger count left over after a sel change runs up to its maximum and wraps.
module retospect_leak_prescaler
  import retospect_neuro_pkg::*;
#(
  parameter int PRESCALE_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic [DSEL_W-1:0] sel_i,
  output logic              tick_o
);

  logic [PRESCALE_W-1:0] count_q, count_d;
  logic [PRESCALE_W-1:0] termVal;

  // Terminal count 2^sel - 1 is a run of sel ones from the LSB.
  always_comb begin
    termVal = '0;
    for (int i = 0; i < PRESCALE_W; i++) begin
      termVal[i] = (i < int'(sel_i));
    end
  end

  assign tick_o = (sel_i != '0) && (count_q == termVal);

  always_comb begin
    count_d = count_q + PRESCALE_W'(1);
    if (clear_i || (sel_i == '0) || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/retospect_lif_core.sv
// Leaky integrate-and-fire core for one CNB, frozen and cleared while config_en is high.
// Optional fire counter output enabled by defining RETOSPECT_SPIKE_COUNT_EN.
module retospect_lif_core
  import retospect_neuro_pkg::*;
#(
  parameter int POT_W      = 6,
  parameter int REFRACT    = 2,
  parameter int PRESCALE_W = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic [CFG_W_BITS-1:0]   cfg_w,
  input  logic [UT_W-1:0]         cfg_ut,
  input  logic [DSEL_W-1:0]       cfg_decay_sel,
  input  logic [N_SYN-1:0]        spike_in,
  output logic                    spike_out,
  output logic signed [POT_W-1:0] pot_out
`ifdef RETOSPECT_SPIKE_COUNT_EN
  ,
  output logic [7:0]              spike_count
`endif
);

  localparam int EXT_W = ((POT_W > 5) ? POT_W : 5) + 2;
  localparam int RW    = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [EXT_W-1:0] POT_MAX = EXT_W'((1 << (POT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] POT_MIN = EXT_W'(-(1 << (POT_W - 1)));
  localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT);

  cfg_t cfg;
  logic signed [POT_W-1:0] pot_q, pot_d;
  logic                    spike_q, spike_d;
  logic [RW-1:0]           refr_q, refr_d;
  logic                    leakTick, fireNow;
  logic signed [EXT_W-1:0] synSum, leakDelta, rawSum, satSum, utExt;

  assign cfg = '{dsel: cfg_decay_sel, ut: cfg_ut, w: cfg_w};

  retospect_leak_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear_i (config_en),
    .sel_i   (cfg.dsel),
    .tick_o  (leakTick)
  );

  always_comb begin
    synSum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (spike_in[i]) begin
        synSum = synSum + EXT_W'(weight_at(cfg.w, i));
      end
    end
  end

  // Leak pulls toward zero, judged on the potential before this cycle's input.
  always_comb begin
    leakDelta = '0;
    if (leakTick) begin
      if (pot_q > 0) begin
        leakDelta = EXT_W'(-1);
      end else if (pot_q < 0) begin
        leakDelta = EXT_W'(1);
      end
    end
    rawSum = EXT_W'(pot_q) + synSum + leakDelta;
    if (rawSum > POT_MAX) begin
      satSum = POT_MAX;
    end else if (rawSum < POT_MIN) begin
      satSum = POT_MIN;
    end else begin
      satSum = rawSum;
    end
    utExt = $signed({{(EXT_W - UT_W){1'b0}}, cfg.ut});
  end

  assign fireNow = !config_en && (refr_q == '0) && (satSum > utExt);

  always_comb begin
    pot_d   = pot_q;
    spike_d = 1'b0;
    refr_d  = refr_q;
    if (config_en) begin
      pot_d  = '0;
      refr_d = '0;
    end else if (refr_q != '0) begin
      pot_d  = '0;
      refr_d = refr_q - RW'(1);
    end else if (fireNow) begin
      pot_d   = '0;
      spike_d = 1'b1;
      refr_d  = REFRACT_LOAD;
    end else begin
      pot_d = satSum[POT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pot_q   <= '0;
      spike_q <= 1'b0;
      refr_q  <= '0;
    end else begin
      pot_q   <= pot_d;
      spike_q <= spike_d;
      refr_q  <= refr_d;
    end
  end

  assign pot_out   = pot_q;
  assign spike_out = spike_q;

`ifdef RETOSPECT_SPIKE_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (config_en) begin
      count_d = '0;
    end else if (fireNow && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign spike_count = count_q;
`endif

endmodule
